// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity-protected serial byte path.
// Holds the frame state encoding and the line levels of the framing bits.
// The matching serialiser uses the same definitions, so its frames and this
// receiver's frames cannot drift apart.
package parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating error counter with a synchronous clear.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, count returns to 0
//   clear - synchronous clear; when inc is also high the count becomes 1
//   inc   - add one, unless the count is already all-ones
//   count - current error count
module parity_err_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      // The erroring frame that completes alongside the clear is still counted.
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Receive end of the parity-protected byte path.
// Deserialises frames of: start bit (0), DATA_W data bits LSB first, a parity
// bit, and a stop bit (1). Parity is the XOR of the data bits, inverted when
// ODD_PARITY=1. The line is sampled only in bit_en cycles.
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   bit_en      - bit strobe; rx_bit is sampled only when high
//   rx_bit      - serial line, idle high
//   clear_cnt   - synchronous clear of err_count
//   data_out    - last received word, held until the next frame completes
//   data_valid  - one-cycle pulse after the stop bit is sampled
//   parity_err  - parity mismatch on the last completed frame
//   frame_err   - stop bit of the last completed frame was 0
//   busy        - frame in progress
//   err_count   - saturating count of frames with any error
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  input  logic              clear_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              rx_par;
  logic              complete;
  logic              par_bad;
  logic              stop_bad;
  logic              err_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE:    if (rx_bit == START_BIT) state_nxt = DATA;
        DATA:    if (bit_idx == LAST_IDX) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          // A low stop bit is not a start bit; a fresh start is needed.
          state_nxt = IDLE;
          complete  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign par_bad  = (rx_par != ((^shreg) ^ (ODD_PARITY != 0)));
  assign stop_bad = (rx_bit != STOP_BIT);
  assign err_inc  = complete && (par_bad || stop_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx    <= '0;
      shreg      <= '0;
      rx_par     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= complete;
      if (bit_en) begin
        unique case (state)
          IDLE: bit_idx <= '0;
          DATA: begin
            shreg[bit_idx] <= rx_bit;
            bit_idx        <= bit_idx + IDX_W'(1);
          end
          PARITY: rx_par <= rx_bit;
          default: ;
        endcase
      end
      if (complete) begin
        data_out   <= shreg;
        parity_err <= par_bad;
        frame_err  <= stop_bad;
      end
    end
  end

  parity_err_counter #(
    .CNT_W(CNT_W)
  ) u_err_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear_cnt),
    .inc  (err_inc),
    .count(err_count)
  );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx. The stimulus tasks know each frame's content,
// so the reference derives every output from frame-level facts.
module tb_parity_frame_rx;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ODD_PARITY = 0;
  localparam int unsigned CNT_W      = 2;
  localparam int          CMAX       = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              bit_en;
  logic              rx_bit;
  logic              clear_cnt;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  parity_frame_rx #(
    .DATA_W    (DATA_W),
    .ODD_PARITY(ODD_PARITY),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .rx_bit    (rx_bit),
    .clear_cnt (clear_cnt),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level facts about the current cycle, set by the stimulus tasks.
  logic              m_stop;
  logic              m_busy_nxt;
  logic [DATA_W-1:0] m_data;
  logic              m_perr;
  logic              m_ferr;

  // Reference outputs.
  logic              e_valid;
  logic              e_busy;
  logic [DATA_W-1:0] e_data;
  logic              e_perr;
  logic              e_ferr;
  int                e_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_busy  <= 1'b0;
      e_data  <= '0;
      e_perr  <= 1'b0;
      e_ferr  <= 1'b0;
      e_cnt   <= 0;
    end else begin
      e_valid <= m_stop;
      e_busy  <= m_busy_nxt;
      if (m_stop) begin
        e_data <= m_data;
        e_perr <= m_perr;
        e_ferr <= m_ferr;
      end
      if (clear_cnt)
        e_cnt <= (m_stop && (m_perr || m_ferr)) ? 1 : 0;
      else if (m_stop && (m_perr || m_ferr))
        e_cnt <= (e_cnt < CMAX) ? e_cnt + 1 : CMAX;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("data_valid", int'(data_valid), int'(e_valid));
      check("busy", int'(busy), int'(e_busy));
      check("err_count", int'(err_count), e_cnt);
      check("data_out", int'(data_out), int'(e_data));
      check("parity_err", int'(parity_err), int'(e_perr));
      check("frame_err", int'(frame_err), int'(e_ferr));
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic tick(input logic en, input logic b, input logic stp, input logic busy_after);
    bit_en     = en;
    rx_bit     = b;
    m_stop     = stp;
    m_busy_nxt = busy_after;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    m_stop    = 1'b0;
  endtask

  task automatic idle(input int unsigned n, input bit rand_clr);
    for (int unsigned i = 0; i < n; i++) begin
      if (rand_clr) clear_cnt = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) tick(1'b1, 1'b1, 1'b0, 1'b0);
      else                           tick(1'b0, 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stp,
                            input int unsigned gmin, input int unsigned gmax, input bit clr_stop);
    logic [DATA_W+2:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int unsigned k = 0; k < DATA_W + 3; k++) begin
      int unsigned g;
      g = $urandom_range(gmax, gmin);
      for (int unsigned j = 0; j < g; j++) tick(1'b0, 1'($urandom), 1'b0, k > 0);
      if (k == DATA_W + 2) begin
        m_data    = d;
        m_perr    = (par != ((^d) ^ (ODD_PARITY != 0)));
        m_ferr    = ~stp;
        clear_cnt = clr_stop;
      end
      tick(1'b1, bits[k], k == DATA_W + 2, k < DATA_W + 2);
    end
  endtask

  function automatic logic good_par(input logic [DATA_W-1:0] d);
    return (^d) ^ (ODD_PARITY != 0);
  endfunction

  initial begin
    logic [DATA_W+2:0] pbits;
    rst_n = 1'b0; bit_en = 1'b0; rx_bit = 1'b1; clear_cnt = 1'b0;
    m_stop = 1'b0; m_busy_nxt = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst data_out", int'(data_out), 0);
    check("rst data_valid", int'(data_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst err_count", int'(err_count), 0);
    rst_n = 1'b1;
    idle(3, 0);

    send_frame(8'h01, 1'b1, 1'b1, 0, 1, 0);
    check("t1 valid", int'(data_valid), 1);
    check("t1 data", int'(data_out), 'h01);
    check("t1 perr", int'(parity_err), 0);
    check("t1 ferr", int'(frame_err), 0);
    check("t1 cnt", int'(err_count), 0);
    idle(2, 0);

    send_frame(8'hDF, 1'b0, 1'b1, 0, 1, 0);
    check("t2 data", int'(data_out), 'hDF);
    check("t2 perr", int'(parity_err), 1);
    check("t2 cnt", int'(err_count), 1);
    idle(2, 0);

    send_frame(8'h55, 1'b0, 1'b0, 0, 1, 0);
    check("t3 ferr", int'(frame_err), 1);
    check("t3 perr", int'(parity_err), 0);
    check("t3 cnt", int'(err_count), 2);
    idle(2, 0);

    send_frame(8'hAA, 1'b0, 1'b1, 2, 2, 0);
    check("t4a data", int'(data_out), 'hAA);
    check("t4a valid", int'(data_valid), 1);
    send_frame(8'h03, 1'b0, 1'b1, 2, 2, 0);
    check("t4b data", int'(data_out), 'h03);
    check("t4b valid", int'(data_valid), 1);
    check("t4b errs", int'({parity_err, frame_err}), 0);
    check("t4b cnt", int'(err_count), 2);

    clear_cnt = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("clr cnt", int'(err_count), 0);
    for (int i = 0; i < 5; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      send_frame(d, ~good_par(d), 1'b1, 0, 1, 0);
    end
    check("sat cnt", int'(err_count), 3);
    send_frame(8'h3C, 1'b1, 1'b1, 0, 1, 1);
    check("clr+err cnt", int'(err_count), 1);
    idle(1, 0);

    pbits = {1'b1, 1'b1, 8'h5A, 1'b0};
    for (int unsigned k = 0; k < 5; k++) tick(1'b1, pbits[k], 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid rst data_out", int'(data_out), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst cnt", int'(err_count), 0);
    check("mid rst flags", int'({data_valid, parity_err, frame_err}), 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2, 0);
    send_frame(8'h80, 1'b1, 1'b1, 0, 1, 0);
    check("t6 data", int'(data_out), 'h80);
    check("t6 errs", int'({parity_err, frame_err}), 0);
    check("t6 cnt", int'(err_count), 0);

    for (int i = 0; i < 60; i++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d),
                 ($urandom_range(0, 5) != 0), 0, 3, ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2), 1);
    end
    idle(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive end of the parity-protected byte path: deserialises a framed serial stream, checks the parity bit and flags framing errors.
- Frame: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
- Parity convention matches the team's parity generator: parity bit = XOR of the 8 data bits (even parity over 9 bits), or its inverse when ODD_PARITY=1.
- Sits after the serial link. Presents each received byte with status flags, and keeps a saturating error count for diagnostics.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- ODD_PARITY, 0, 0: expected parity = ^data; 1: expected parity = ~^data.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  bit strobe; rx_bit is sampled only in cycles where bit_en=1.
- rx_bit  input  1  serial line, idle high.
- clear_cnt  input  1  synchronous clear of err_count.
- data_out  output  DATA_W  last received data word, held until the next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on the frame reported by data_valid.
- frame_err  output  1  stop bit sampled as 0 on that frame.
- busy  output  1  high while a frame is in progress (state != IDLE).
- err_count  output  CNT_W  count of frames with parity_err or frame_err; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0, bit index=0, shift register=0.
- All state changes happen only in bit_en=1 cycles, except the data_valid clear and clear_cnt, which act every cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: bit_en=1 and rx_bit=0 -> DATA, bit index=0. rx_bit=1 -> stay in IDLE.
  - DATA: on each bit_en, shift rx_bit into bit[index] (LSB first). After index=DATA_W-1 -> PARITY.
  - PARITY: on bit_en, latch rx_bit as the received parity -> STOP.
  - STOP: on bit_en -> IDLE.
- STOP completion, registered on the clock edge that samples the stop bit:
  - data_out <= shifted word.
  - parity_err <= (received parity != expected parity).
  - frame_err <= ~rx_bit.
  - data_valid <= 1 for exactly one cycle.
- Latency: data_valid is high in the cycle immediately after the bit_en cycle that sampled the stop bit.
- parity_err and frame_err are held until the next completion. data_out is updated even on error.
- err_count:
  - Increments by 1 at completion if parity_err or frame_err (one increment per frame even if both).
  - Saturates at 2^CNT_W-1.
  - clear_cnt=1 sets err_count to 0. If clear_cnt coincides with an erroring completion, err_count becomes 1.
- A 0 on the stop bit is not treated as a new start bit; the FSM returns to IDLE and needs a fresh 0 on a later bit_en.
- bit_en=0 in the middle of a frame: the FSM holds its state indefinitely. There is no timeout.
- Reset mid-frame: the partial frame is discarded, no data_valid is produced, and err_count returns to 0.
- Back-to-back frames: a start bit on the bit_en immediately after the stop bit is accepted (minimum of 0 idle bits).

Decomposition:
- Shared package: state encoding typedef (IDLE/DATA/PARITY/STOP) and the START_BIT=0 / STOP_BIT=1 constants, reused by the matching serialiser.
- One sub-module: parity_err_counter (saturating counter with clear and increment; parameter CNT_W).
- Parity compare stays inline as an XOR reduction.

Test Plan:
- Reset then frame start=0, data 8'h01, parity=1, stop=1 -> data_out=8'h01, data_valid one cycle, parity_err=0, frame_err=0, err_count=0.
- Frame data 8'hDF (seven ones) with parity bit 0 -> parity_err=1, err_count=1, data_out=8'hDF.
- Frame data 8'h55, parity 0, stop bit 0 -> frame_err=1, parity_err=0, err_count increments by 1.
- Two back-to-back frames 8'hAA then 8'h03 (both with correct parity), bit_en every 3 clks -> two data_valid pulses, data_out 8'hAA then 8'h03, no errors.
- CNT_W=2: five erroring frames -> err_count saturates at 3. clear_cnt asserted in the same cycle as a sixth erroring completion -> err_count=1.
- rst_n dropped after 4 data bits of a frame -> all outputs 0 immediately. A following frame 8'h80 with parity 1 -> received correctly, data_out=8'h80, no errors.
